// File: rtl/sarray_pkg.sv
// rtl/sarray_pkg.sv - shared widths, FSM states and FIFO entry type for the STOREC drain stage
package sarray_pkg;

  localparam int ADDR_WIDTH       = 64;
  localparam int STORE_WIDTH      = 512;
  localparam int CNT_WIDTH        = 6;
  localparam int ROW_STRIDE_SHIFT = 8;
  localparam int FIFO_DEPTH       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } storec_state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]   cnt;
    logic [STORE_WIDTH-1:0] data;
  } storec_entry_t;

endpackage

// File: rtl/storec_fifo.sv
// rtl/storec_fifo.sv - single-clock FIFO; a push while full is accepted only when a pop frees the slot
module storec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sarray_storec.sv
// rtl/sarray_storec.sv - STOREC drain: buffers bottom-edge result rows and issues one AW write per row
// Optional AW output skid slice enabled by SARRAY_STOREC_OUT_REG_EN
module sarray_storec #(
  parameter int ADDR_WIDTH       = sarray_pkg::ADDR_WIDTH,
  parameter int STORE_WIDTH      = sarray_pkg::STORE_WIDTH,
  parameter int CNT_WIDTH        = sarray_pkg::CNT_WIDTH,
  parameter int ROW_STRIDE_SHIFT = sarray_pkg::ROW_STRIDE_SHIFT,
  parameter int FIFO_DEPTH       = sarray_pkg::FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   storec_valid_i,
  output logic                   storec_ready_o,
  input  logic [ADDR_WIDTH-1:0]  storec_addr_i,
  input  logic                   bot_valid_i,
  input  logic [CNT_WIDTH-1:0]   bot_cnt_i,
  input  logic [STORE_WIDTH-1:0] bot_data_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  aw_addr_o,
  output logic [STORE_WIDTH-1:0] aw_data_o,
  output logic                   storec_done_o,
  output logic                   overflow_o
);

  import sarray_pkg::*;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]   cnt;
    logic [STORE_WIDTH-1:0] data;
  } entry_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  storec_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_WIDTH-1:0]    rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0]    tx_cnt_q, tx_cnt_d;
  logic                    overflow_q, overflow_d;

  logic                    cmd_fire, row_push, aw_fire;
  logic                    fifo_pop, fifo_full, fifo_empty;
  entry_t                  fifo_wdata, fifo_rdata;
  logic [ADDR_WIDTH-1:0]   head_addr;

  assign storec_ready_o = (state_q == IDLE);
  assign cmd_fire       = storec_valid_i && storec_ready_o;
  assign row_push       = (state_q == DRAIN) && bot_valid_i;
  assign aw_fire        = aw_valid_o && aw_ready_i;
  assign overflow_o     = overflow_q;
  assign storec_done_o  = aw_fire && (tx_cnt_q == CNT_MAX) && (state_q == FLUSH);

  assign fifo_wdata = {bot_cnt_i, bot_data_i};
  assign head_addr  = base_q + (ADDR_WIDTH'(fifo_rdata.cnt) << ROW_STRIDE_SHIFT);

  storec_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (row_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    // A row that finds the FIFO full with nothing leaving is lost; the flag never self-clears.
    overflow_d = overflow_q || (row_push && fifo_full && !fifo_pop);
    if (row_push) rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
    if (aw_fire)  tx_cnt_d = tx_cnt_q + CNT_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          base_d   = storec_addr_i;
          rx_cnt_d = '0;
          tx_cnt_d = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (row_push && (rx_cnt_q == CNT_MAX)) state_d = FLUSH;
      end
      FLUSH: begin
        if (storec_done_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SARRAY_STOREC_OUT_REG_EN
  logic                   out_vld_q, out_vld_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [STORE_WIDTH-1:0] out_data_q, out_data_d;
  logic                   skid_vld_q, skid_vld_d;
  logic [ADDR_WIDTH-1:0]  skid_addr_q, skid_addr_d;
  logic [STORE_WIDTH-1:0] skid_data_q, skid_data_d;

  // Accepting while the skid is occupied is safe only when the output drains this cycle.
  assign fifo_pop = !fifo_empty && (!skid_vld_q || aw_ready_i);

  always_comb begin
    out_vld_d   = out_vld_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    if (!out_vld_q || aw_ready_i) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_addr_d  = skid_addr_q;
        out_data_d  = skid_data_q;
        skid_vld_d  = fifo_pop;
        skid_addr_d = head_addr;
        skid_data_d = fifo_rdata.data;
      end else begin
        out_vld_d   = fifo_pop;
        out_addr_d  = head_addr;
        out_data_d  = fifo_rdata.data;
      end
    end else if (fifo_pop) begin
      skid_vld_d  = 1'b1;
      skid_addr_d = head_addr;
      skid_data_d = fifo_rdata.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    out_addr_q  <= out_addr_d;
    out_data_q  <= out_data_d;
    skid_addr_q <= skid_addr_d;
    skid_data_q <= skid_data_d;
  end

  assign aw_valid_o = out_vld_q;
  assign aw_addr_o  = out_addr_q;
  assign aw_data_o  = out_data_q;
`else
  assign fifo_pop   = aw_fire;
  assign aw_valid_o = !fifo_empty;
  assign aw_addr_o  = head_addr;
  assign aw_data_o  = fifo_rdata.data;
`endif

endmodule

// File: doc/sarray_storec.md
Name: sarray_storec

Overview:
- Downstream drain stage of the systolic-array top.
- Captures result rows leaving the array's bottom edge during a STOREC instruction, buffers them, and emits one write request per row on the sarray AW channel.
- Signals instruction completion back to the array top so its tinst slot can be released.
- The array has no backpressure; this block absorbs rate mismatch with an internal FIFO.

Parameters:
- ADDR_WIDTH, 64, write address width.
- STORE_WIDTH, 512, bits per result row (equals `SARRAY_STORE_WIDTH).
- CNT_WIDTH, 6, row index width; rows per instruction = 2**CNT_WIDTH.
- ROW_STRIDE_SHIFT, 8, byte stride per row = 1<<ROW_STRIDE_SHIFT.
- FIFO_DEPTH, 8, row buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- storec_valid_i  in  1  STOREC command valid.
- storec_ready_o  out  1  command accepted when valid&ready.
- storec_addr_i  in  ADDR_WIDTH  destination base address.
- bot_valid_i  in  1  result row valid from array bottom edge.
- bot_cnt_i  in  CNT_WIDTH  row index of bot_data_i.
- bot_data_i  in  STORE_WIDTH  result row.
- aw_valid_o  out  1  write request valid.
- aw_ready_i  in  1  write request accepted.
- aw_addr_o  out  ADDR_WIDTH  base + (cnt << ROW_STRIDE_SHIFT), truncated to ADDR_WIDTH.
- aw_data_o  out  STORE_WIDTH  row data.
- storec_done_o  out  1  one-cycle pulse when the last row's AW handshake completes.
- overflow_o  out  1  sticky: row arrived with FIFO full.

Behaviour:
- Reset: FSM=IDLE, FIFO empty, row counters 0, storec_ready_o=1, aw_valid_o=0, storec_done_o=0, overflow_o=0. Reset mid-operation discards all buffered rows with no AW emitted.
- FSM IDLE:
  - storec_ready_o=1.
  - On command handshake, latch base address, clear rx_cnt/tx_cnt, and go to DRAIN.
  - bot_valid_i in IDLE is ignored and not counted.
- FSM DRAIN:
  - storec_ready_o=0.
  - Each bot_valid_i pushes {bot_cnt_i, bot_data_i} into the FIFO and increments rx_cnt.
  - When rx_cnt wraps (last row pushed), go to FLUSH.
- FSM FLUSH: wait until tx_cnt wraps, then go to IDLE in the same cycle as the storec_done_o pulse.
- Both counters are CNT_WIDTH wide; "wrap" means a handshake occurs while the counter is all-ones.
- AW: aw_valid_o = FIFO non-empty; head entry drives addr and data.
  - Pop and tx_cnt++ on aw_valid_o & aw_ready_i.
  - aw_valid_o, once high, holds and addr/data stay stable until the handshake.
- FIFO:
  - Push and pop in the same cycle: both take effect and occupancy is unchanged. This is legal when full, since the pop frees a slot first.
  - Push when full without a pop: row dropped, rx_cnt still increments, overflow_o set (cleared only by rst).
  - A dropped row means tx_cnt never wraps. Recovery is by rst only.
- Command-to-first-AW latency: 1 cycle after the first bot_valid_i (the FIFO registers the entry).
- storec_ready_o returns to 1 in the cycle after storec_done_o.

Optional Feature:
- Macro SARRAY_STOREC_OUT_REG_EN.
- Defined: a full-throughput skid register slice sits between the FIFO head and the AW port.
  - AW latency from push becomes 2 cycles.
  - Effective buffering becomes FIFO_DEPTH+2.
  - storec_done_o is still tied to the final AW handshake.
- Undefined: the FIFO head drives the AW port directly, with 1-cycle latency.

Decomposition:
- Package sarray_pkg holds:
  - width constants ADDR_WIDTH, STORE_WIDTH, CNT_WIDTH, ROW_STRIDE_SHIFT;
  - the FSM state enum {IDLE, DRAIN, FLUSH};
  - the FIFO entry struct {cnt, data}.
- One sub-module: storec_fifo, a synchronous single-clock FIFO with push/pop/full/empty and parameters WIDTH and DEPTH.

Test Plan:
- Basic: reset; command base=0x1000; 64 rows cnt 0..63 back-to-back with aw_ready_i=1 -> 64 AW, addr 0x1000 + i*0x100 in order, data matches; storec_done_o pulses once on AW #63; storec_ready_o high the next cycle.
- Backpressure: aw_ready_i low for 7 cycles from row 0, then high, with FIFO_DEPTH=8 -> no overflow, aw_valid_o/addr/data stable while stalled, all 64 rows written.
- Overflow: aw_ready_i held 0, 9 rows pushed -> overflow_o=1 from the cycle after row 9 and stays set; done never pulses; rst clears overflow_o and empties the FIFO.
- Push/pop when full: FIFO full, bot_valid_i and aw_ready_i both high -> occupancy stays 8, overflow_o stays 0.
- Reset mid-DRAIN after 20 rows -> aw_valid_o=0 in the cycle after rst; a new command at base 0x0 completes cleanly with 64 writes.
- Address wrap: base=0xFFFF_FFFF_FFFF_FF00 -> row 1 address 0x0 (truncated); with SARRAY_STOREC_OUT_REG_EN, the Basic test gives first AW 2 cycles after the first row.
